// File: rtl/qos_pkg.sv
// Shared types and helpers for the QoS egress drain path.
package qos_pkg;

    localparam int unsigned QOS_BUF_WIDTH = 3;
    localparam int unsigned QOS_WORD_W    = QOS_BUF_WIDTH + 1;

    typedef logic [QOS_BUF_WIDTH:0] qos_word_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_state_t;

    // Words committed to the skid buffer once this cycle settles: held + arriving - leaving.
    function automatic logic [2:0] commit_level(occ_state_t occ, logic inflight, logic pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry in-order skid buffer; head is the oldest word and is held while not popped.
module skid_buffer2
    import qos_pkg::*;
#(
    parameter int unsigned WIDTH = QOS_WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] tail;

    // Push appends behind the head; a simultaneous pop shifts first so order is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occupancy == 2'd0) begin
                        head <= din;
                    end else begin
                        tail <= din;
                    end
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    if (occupancy == 2'd2) begin
                        head <= tail;
                    end
                    occupancy <= occupancy - 2'd1;
                end
                2'b11: begin
                    if (occupancy == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/qos_egress.sv
// Drains the QoS output FIFO into a 2-entry skid buffer and presents words on valid/ready.
// Also tracks accepted words (saturating) and an idle flag after a run of quiet cycles.
module qos_egress
    import qos_pkg::*;
#(
    parameter int unsigned BUF_WIDTH   = QOS_BUF_WIDTH,
    parameter int unsigned CNT_BITS    = 16,
    parameter int unsigned IDLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enb,
    input  logic                fifo_empty,
    input  logic [BUF_WIDTH:0]  fifo_dout,
    output logic                fifo_rd_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUF_WIDTH:0]  out_data,
    output logic [CNT_BITS-1:0] words_sent,
    output logic                idle
);

    localparam int unsigned WORD_W = BUF_WIDTH + 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    occ_state_t        state;
    occ_state_t        state_d;
    logic              inflight;
    logic              push;
    logic              pop;
    logic              quiet;
    logic [1:0]        occupancy;
    logic [IDLE_W-1:0] quiet_cnt;
    logic [IDLE_W-1:0] quiet_cnt_d;

    assign push      = inflight;
    assign pop       = out_valid & out_ready;
    assign out_valid = (occupancy != 2'd0);

    skid_buffer2 #(
        .WIDTH(WORD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (fifo_dout),
        .head      (out_data),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_d;
        end
    end

    // Occupancy FSM plus read issue; a read is only issued if its word is guaranteed a slot.
    always_comb begin
        state_d    = state;
        fifo_rd_en = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (push) begin
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && !pop) begin
                    state_d = S_TWO;
                end else if (!push && pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop && !push) begin
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
        fifo_rd_en = rst & enb & ~fifo_empty & (commit_level(state, inflight, pop) <= 3'd1);
    end

    // The FIFO returns data one cycle after the pop request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_sent <= '0;
        end else if (pop && (words_sent != '1)) begin
            words_sent <= words_sent + CNT_BITS'(1);
        end
    end

    assign quiet = fifo_empty & (state == S_EMPTY) & ~inflight;

    always_comb begin
        quiet_cnt_d = '0;
        if (quiet) begin
            if (quiet_cnt == IDLE_W'(IDLE_CYCLES)) begin
                quiet_cnt_d = quiet_cnt;
            end else begin
                quiet_cnt_d = quiet_cnt + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quiet_cnt <= '0;
            idle      <= 1'b0;
        end else begin
            quiet_cnt <= quiet_cnt_d;
            idle      <= (quiet_cnt_d == IDLE_W'(IDLE_CYCLES));
        end
    end

endmodule

// File: tb/tb_qos_egress.sv
// Bench for qos_egress: FIFO model, in-order scoreboard, per-cycle vector tables and corner sequences.
module tb_qos_egress;

    typedef struct packed {
        logic        enb;
        logic        ready;
        logic        rd;
        logic        valid;
        logic [3:0]  data;
        logic [15:0] ws;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enb = 1'b0;
    logic        out_ready = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [3:0]  fifo_dout = 4'd0;
    logic        fifo_rd_en;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [15:0] words_sent;
    logic        idle;
    logic        sat_rd_en;
    logic        sat_valid;
    logic [3:0]  sat_data;
    logic [1:0]  sat_ws;
    logic        sat_idle;

    logic [3:0]  fq[$];
    logic [3:0]  exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    vec_t        vec [19];

    always #5 clk = ~clk;

    qos_egress u_dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .words_sent (words_sent),
        .idle       (idle)
    );

    qos_egress #(.CNT_BITS(2)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (sat_rd_en),
        .out_valid  (sat_valid),
        .out_ready  (out_ready),
        .out_data   (sat_data),
        .words_sent (sat_ws),
        .idle       (sat_idle)
    );

    // FIFO model: data appears the cycle after the pop request.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
    endtask

    // Scoreboard: every accepted word must be the oldest outstanding one.
    always @(negedge clk) begin
        #3;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got word %0d, want none", out_data);
            end else begin
                chk("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
                delivered++;
            end
        end
    end

    function automatic vec_t mk(logic e, logic r, logic rd, logic v, logic [3:0] d, logic [15:0] ws);
        vec_t t;
        t.enb = e; t.ready = r; t.rd = rd; t.valid = v; t.data = d; t.ws = ws;
        return t;
    endfunction

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            enb       = vec[i].enb;
            out_ready = vec[i].ready;
            #3;
            chk($sformatf("rd[%0d]", i), 32'(fifo_rd_en), 32'(vec[i].rd));
            chk($sformatf("valid[%0d]", i), 32'(out_valid), 32'(vec[i].valid));
            if (vec[i].valid) begin
                chk($sformatf("data[%0d]", i), 32'(out_data), 32'(vec[i].data));
                chk($sformatf("sat_data[%0d]", i), 32'(sat_data), 32'(vec[i].data));
            end
            chk($sformatf("ws[%0d]", i), 32'(words_sent), 32'(vec[i].ws));
            chk($sformatf("sat_rd[%0d]", i), 32'(sat_rd_en), 32'(vec[i].rd));
            chk($sformatf("sat_valid[%0d]", i), 32'(sat_valid), 32'(vec[i].valid));
            chk($sformatf("sat_ws[%0d]", i), 32'(sat_ws), (vec[i].ws > 16'd3) ? 32'd3 : 32'(vec[i].ws));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        // Streaming 3,5,7,9 with ready held high (words_sent starts at 1).
        vec[0]  = mk(1, 1, 1, 0, 4'd0, 16'd1);
        vec[1]  = mk(1, 1, 1, 0, 4'd0, 16'd1);
        vec[2]  = mk(1, 1, 1, 1, 4'd3, 16'd1);
        vec[3]  = mk(1, 1, 1, 1, 4'd5, 16'd2);
        vec[4]  = mk(1, 1, 0, 1, 4'd7, 16'd3);
        vec[5]  = mk(1, 1, 0, 1, 4'd9, 16'd4);
        vec[6]  = mk(1, 1, 0, 0, 4'd0, 16'd5);
        // Backpressure with 1,2,4,8,11,13 queued: two reads, head held, then in-order drain.
        vec[7]  = mk(1, 0, 1, 0, 4'd0, 16'd5);
        vec[8]  = mk(1, 0, 1, 0, 4'd0, 16'd5);
        vec[9]  = mk(1, 0, 0, 1, 4'd1, 16'd5);
        vec[10] = mk(1, 0, 0, 1, 4'd1, 16'd5);
        vec[11] = mk(1, 0, 0, 1, 4'd1, 16'd5);
        vec[12] = mk(1, 1, 1, 1, 4'd1, 16'd5);
        vec[13] = mk(1, 1, 1, 1, 4'd2, 16'd6);
        vec[14] = mk(1, 1, 1, 1, 4'd4, 16'd7);
        vec[15] = mk(1, 1, 1, 1, 4'd8, 16'd8);
        vec[16] = mk(1, 1, 0, 1, 4'd11, 16'd9);
        vec[17] = mk(1, 1, 0, 1, 4'd13, 16'd10);
        vec[18] = mk(1, 1, 0, 0, 4'd0, 16'd11);

        // Reset values.
        rst = 1'b0;
        enb = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_rd", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ws", 32'(words_sent), 0);
        chk("rst_idle", 32'(idle), 0);
        @(negedge clk);
        rst = 1'b1;

        // Idle ramps on the 4th quiet cycle, drops one cycle after the FIFO becomes non-empty.
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle_ramp[%0d]", k), 32'(idle), (k >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("sat_idle_ramp[%0d]", k), 32'(sat_idle), (k >= 4) ? 32'd1 : 32'd0);
        end
        enb = 1'b0;
        load(4'd6);
        @(posedge clk);
        #1;
        chk("idle_hold", 32'(idle), 1);
        chk("enb_low_rd", 32'(fifo_rd_en), 0);
        @(posedge clk);
        #1;
        chk("idle_drop", 32'(idle), 0);
        enb = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Reset while one word is buffered and one is in flight; both are discarded.
        @(negedge clk);
        out_ready = 1'b0;
        load(4'd12);
        load(4'd14);
        load(4'd15);
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!out_valid && n < 10);
        chk("mid_reach_valid", 32'(out_valid), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_rd", 32'(fifo_rd_en), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        exp_q.delete();
        exp_q.push_back(4'd15);
        @(negedge clk);
        #3;
        chk("mid_rst_rd_hold", 32'(fifo_rd_en), 0);
        @(negedge clk);
        rst = 1'b1;
        #3;
        chk("mid_rel_ws", 32'(words_sent), 0);
        chk("mid_rel_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Streaming table.
        @(negedge clk);
        load(4'd3);
        load(4'd5);
        load(4'd7);
        load(4'd9);
        run_rows(0, 6);

        // Backpressure table.
        @(negedge clk);
        out_ready = 1'b0;
        load(4'd1);
        load(4'd2);
        load(4'd4);
        load(4'd8);
        load(4'd11);
        load(4'd13);
        run_rows(7, 18);

        // Alternating ready: order kept, nothing lost or duplicated.
        @(negedge clk);
        d0 = delivered;
        for (int i = 0; i < 8; i++) begin
            load(4'((i * 5 + 2) % 16));
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            out_ready = (i % 2 == 1);
        end
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("alt_count", 32'(delivered - d0), 8);

        // enb dropped the cycle after a read: that word still arrives, no further reads.
        @(negedge clk);
        d0 = delivered;
        load(4'd2);
        load(4'd7);
        load(4'd12);
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!fifo_rd_en && n < 10);
        chk("enb_first_rd", 32'(fifo_rd_en), 1);
        @(negedge clk);
        enb = 1'b0;
        #3;
        chk("enb_off_rd", 32'(fifo_rd_en), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            chk($sformatf("enb_off_rd[%0d]", i), 32'(fifo_rd_en), 0);
        end
        chk("enb_off_delivered", 32'(delivered - d0), 1);
        enb = 1'b1;
        repeat (8) @(negedge clk);
        chk("enb_on_delivered", 32'(delivered - d0), 3);

        chk("sb_leftover", 32'(exp_q.size()), 0);
        chk("final_ws", 32'(words_sent), 22);
        chk("final_sat_ws", 32'(sat_ws), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
